eth_tx_arb: RTL

Two-input packet arbiter for the 64-bit Ethernet TX stream of the NetTLP adapter. It shares one MAC TX port between two Eth+IP+UDP+TLP encapsulators, for example the RX-snoop and TX-snoop paths. It grants whole packets in round-robin order and never interleaves beats of different packets. Per-input packet counters are exported for the register block.

---
 rtl/eth_tx_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_arb.sv
// Two-input whole-packet round-robin arbiter for the 64-bit Ethernet TX stream.
// Grants are withdrawn if the granted input never starts its packet.
module eth_tx_arb #(
    parameter int unsigned GRANT_TIMEOUT = 64
) (
    input  logic        eth_clk,
    input  logic        eth_rst,

    input  logic        s0_req,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    input  logic [7:0]  s0_tkeep,
    input  logic [63:0] s0_tdata,
    input  logic        s0_tuser,
    output logic        s0_tready,

    input  logic        s1_req,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    input  logic [7:0]  s1_tkeep,
    input  logic [63:0] s1_tdata,
    input  logic        s1_tuser,
    output logic        s1_tready,

    output logic        m_tvalid,
    output logic        m_tlast,
    output logic [7:0]  m_tkeep,
    output logic [63:0] m_tdata,
    output logic        m_tuser,
    input  logic        m_tready,

    output logic [31:0] pkt_cnt0,
    output logic [31:0] pkt_cnt1,
    output logic [15:0] timeout_cnt
);

    localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(GRANT_TIMEOUT - 1);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    arb_state_e     r_state;
    logic           r_grant;
    logic           r_last;
    logic           r_started;
    logic [TW-1:0]  r_to_cnt;
    logic [31:0]    r_pkt_cnt0;
    logic [31:0]    r_pkt_cnt1;
    logic [15:0]    r_timeout_cnt;

    logic           w_busy;
    logic           w_req0;
    logic           w_req1;
    logic           w_sel_tvalid;
    logic           w_sel_tlast;
    logic           w_sel_tuser;
    logic [7:0]     w_sel_tkeep;
    logic [63:0]    w_sel_tdata;
    logic           w_xfer;
    logic           w_done;
    logic           w_to_fire;

    assign w_busy = (r_state == ARB_BUSY);
    assign w_req0 = s0_req | s0_tvalid;
    assign w_req1 = s1_req | s1_tvalid;

    assign w_sel_tvalid = r_grant ? s1_tvalid : s0_tvalid;
    assign w_sel_tlast  = r_grant ? s1_tlast  : s0_tlast;
    assign w_sel_tuser  = r_grant ? s1_tuser  : s0_tuser;
    assign w_sel_tkeep  = r_grant ? s1_tkeep  : s0_tkeep;
    assign w_sel_tdata  = r_grant ? s1_tdata  : s0_tdata;

    // Zero-latency passthrough while busy; everything forced low while idle or in reset.
    assign m_tvalid  = w_busy & w_sel_tvalid;
    assign m_tlast   = w_busy & w_sel_tlast;
    assign m_tuser   = w_busy & w_sel_tuser;
    assign m_tkeep   = w_busy ? w_sel_tkeep : 8'h00;
    assign m_tdata   = w_busy ? w_sel_tdata : 64'h0;
    assign s0_tready = w_busy & ~r_grant & m_tready;
    assign s1_tready = w_busy &  r_grant & m_tready;

    assign w_xfer    = m_tvalid & m_tready;
    assign w_done    = w_xfer & m_tlast;
    // A first tvalid in the firing cycle suppresses the timeout.
    assign w_to_fire = w_busy & ~r_started & ~w_sel_tvalid & (r_to_cnt == TO_LAST);

    always_ff @(posedge eth_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_state       <= ARB_IDLE;
            r_grant       <= 1'b0;
            r_last        <= 1'b1;
            r_started     <= 1'b0;
            r_to_cnt      <= '0;
            r_pkt_cnt0    <= 32'd0;
            r_pkt_cnt1    <= 32'd0;
            r_timeout_cnt <= 16'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_started <= 1'b0;
                    r_to_cnt  <= '0;
                    if (w_req0 || w_req1) begin
                        r_grant <= (w_req0 && w_req1) ? ~r_last : w_req1;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_xfer) begin
                        r_started <= 1'b1;
                    end
                    if (!r_started && !w_sel_tvalid) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                        r_last  <= r_grant;
                        if (r_grant) begin
                            r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
                        end else begin
                            r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
                        end
                    end else if (w_to_fire) begin
                        r_state <= ARB_IDLE;
                        r_last  <= r_grant;
                        if (r_timeout_cnt != 16'hFFFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign pkt_cnt0    = r_pkt_cnt0;
    assign pkt_cnt1    = r_pkt_cnt1;
    assign timeout_cnt = r_timeout_cnt;

endmodule
